// File: rtl/feedback_monitor.sv
// feedback_monitor: decodes game feedback bytes into status flags, frame stats and a wait-for-flag handshake
// Optional stale timer compiled in with `define FEEDBACK_STALE_TIMER_EN
module feedback_monitor #(
    parameter int unsigned STALE_CYCLES = 153600
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] dataOut_bits,
    input  logic       dataOut_valid,
    input  logic       script_mode,
    output logic       traveler_in_front_of_target_machine,
    output logic       traveler_has_item_in_hand,
    output logic       target_machine_is_processing,
    output logic       target_machine_has_item,
    output logic       fb_update,
    output logic       fb_changed,
    output logic [7:0] fb_count,
    output logic [7:0] bad_count,
    output logic       status_stale,
    input  logic       wait_req,
    input  logic [1:0] wait_sel,
    input  logic       wait_level,
    input  logic       wait_cancel,
    output logic       wait_busy,
    output logic       wait_done,
    output logic       wait_ok
);
    typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_prev_valid;
    logic [3:0] r_flags;
    logic       r_fb_update;
    logic       r_fb_changed;
    logic [7:0] r_fb_count;
    logic [7:0] r_bad_count;
    logic [1:0] r_sel;
    logic       r_level;
    logic       r_ok;
    logic       w_take;
    logic       w_fb;
    logic       w_bad;
    logic [3:0] w_frame_flags;
    logic       w_match;
    logic       w_arm;
    logic       w_hit;
    logic       w_stale;
    logic       w_stale_abort;
    logic       w_unused;

    // Bits [7:6] of a frame carry nothing for this block.
    assign w_unused      = &{1'b0, dataOut_bits[7:6]};
    assign w_take        = dataOut_valid & ~r_prev_valid & ~script_mode;
    assign w_fb          = w_take & (dataOut_bits[1:0] == 2'b01);
    assign w_bad         = w_take & (dataOut_bits[1:0] != 2'b01);
    assign w_frame_flags = dataOut_bits[5:2];
    assign w_match       = w_frame_flags[r_sel] == r_level;

    // Edge detector: one acceptance per high period of the UART valid level.
    always_ff @(posedge clock) begin
        if (!reset_n)
            r_prev_valid <= 1'b0;
        else
            r_prev_valid <= dataOut_valid;
    end

    // Flag latch and frame statistics, all updated the cycle after acceptance.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_flags      <= 4'd0;
            r_fb_update  <= 1'b0;
            r_fb_changed <= 1'b0;
            r_fb_count   <= 8'd0;
            r_bad_count  <= 8'd0;
        end else begin
            r_fb_update  <= w_fb;
            r_fb_changed <= w_fb & (w_frame_flags != r_flags);
            if (w_fb) begin
                r_flags    <= w_frame_flags;
                r_fb_count <= r_fb_count + 8'd1;
            end
            if (w_bad && r_bad_count != 8'hFF)
                r_bad_count <= r_bad_count + 8'd1;
        end
    end

`ifdef FEEDBACK_STALE_TIMER_EN
    localparam int unsigned          CW    = $clog2(STALE_CYCLES + 1);
    localparam logic [CW-1:0]        LIMIT = CW'(STALE_CYCLES);

    logic [CW-1:0] r_stale_cnt;
    logic          r_stale_q;

    assign w_stale       = r_stale_cnt == LIMIT;
    assign w_stale_abort = w_stale & ~r_stale_q;

    // Staleness counter: frozen during script download, cleared by any feedback frame.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_stale_cnt <= '0;
            r_stale_q   <= 1'b0;
        end else begin
            r_stale_q <= w_stale;
            if (w_fb)
                r_stale_cnt <= '0;
            else if (!script_mode && r_stale_cnt != LIMIT)
                r_stale_cnt <= r_stale_cnt + 1'b1;
        end
    end
`else
    logic w_unused_stale;

    assign w_unused_stale = STALE_CYCLES == 0;
    assign w_stale        = 1'b0;
    assign w_stale_abort  = 1'b0;
`endif

    // Wait FSM state register.
    always_ff @(posedge clock) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Wait FSM next state: cancel beats a match, a match beats a stale abort.
    always_comb begin
        w_state_nxt = r_state;
        w_arm       = 1'b0;
        w_hit       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (wait_req) begin
                    w_state_nxt = ARMED;
                    w_arm       = 1'b1;
                end
            end
            ARMED: begin
                if (wait_cancel)
                    w_state_nxt = IDLE;
                else if (w_fb && w_match) begin
                    w_state_nxt = DONE;
                    w_hit       = 1'b1;
                end else if (w_stale_abort)
                    w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Wait parameters captured at arming; result held until the next arm.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_sel   <= 2'd0;
            r_level <= 1'b0;
            r_ok    <= 1'b0;
        end else if (w_arm) begin
            r_sel   <= wait_sel;
            r_level <= wait_level;
            r_ok    <= 1'b0;
        end else if (w_hit)
            r_ok <= 1'b1;
    end

    assign traveler_in_front_of_target_machine = r_flags[0];
    assign traveler_has_item_in_hand           = r_flags[1];
    assign target_machine_is_processing        = r_flags[2];
    assign target_machine_has_item             = r_flags[3];
    assign fb_update                           = r_fb_update;
    assign fb_changed                          = r_fb_changed;
    assign fb_count                            = r_fb_count;
    assign bad_count                           = r_bad_count;
    assign status_stale                        = w_stale;
    assign wait_busy                           = r_state == ARMED;
    assign wait_done                           = r_state == DONE;
    assign wait_ok                             = r_ok;
endmodule

// File: tb/tb_feedback_monitor.sv
// tb_feedback_monitor: directed and randomized transaction-level checks of feedback_monitor
module tb_feedback_monitor;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] dataOut_bits = 8'd0;
    logic       dataOut_valid = 1'b0;
    logic       script_mode = 1'b0;
    logic       wait_req = 1'b0;
    logic [1:0] wait_sel = 2'd0;
    logic       wait_level = 1'b0;
    logic       wait_cancel = 1'b0;
    logic       traveler_in_front_of_target_machine;
    logic       traveler_has_item_in_hand;
    logic       target_machine_is_processing;
    logic       target_machine_has_item;
    logic       fb_update;
    logic       fb_changed;
    logic [7:0] fb_count;
    logic [7:0] bad_count;
    logic       status_stale;
    logic       wait_busy;
    logic       wait_done;
    logic       wait_ok;
    logic [3:0] flags;

    int n_checks = 0;
    int n_fail = 0;

    logic [3:0] m_flags;
    logic [7:0] m_fbc;
    logic [7:0] m_bad;
    logic       m_armed;
    logic       m_ok;
    logic [1:0] m_sel;
    logic       m_lvl;
    logic       s_upd;
    logic       s_chg;
    logic       s_done;

    always #5 clock = ~clock;

    assign flags = {target_machine_has_item, target_machine_is_processing,
                    traveler_has_item_in_hand, traveler_in_front_of_target_machine};

    feedback_monitor #(.STALE_CYCLES(32)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .dataOut_bits(dataOut_bits),
        .dataOut_valid(dataOut_valid),
        .script_mode(script_mode),
        .traveler_in_front_of_target_machine(traveler_in_front_of_target_machine),
        .traveler_has_item_in_hand(traveler_has_item_in_hand),
        .target_machine_is_processing(target_machine_is_processing),
        .target_machine_has_item(target_machine_has_item),
        .fb_update(fb_update),
        .fb_changed(fb_changed),
        .fb_count(fb_count),
        .bad_count(bad_count),
        .status_stale(status_stale),
        .wait_req(wait_req),
        .wait_sel(wait_sel),
        .wait_level(wait_level),
        .wait_cancel(wait_cancel),
        .wait_busy(wait_busy),
        .wait_done(wait_done),
        .wait_ok(wait_ok)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        m_flags = 4'd0;
        m_fbc   = 8'd0;
        m_bad   = 8'd0;
        m_armed = 1'b0;
        m_ok    = 1'b0;
        m_sel   = 2'd0;
        m_lvl   = 1'b0;
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        dataOut_valid = 1'b0;
        script_mode   = 1'b0;
        wait_req      = 1'b0;
        wait_cancel   = 1'b0;
        tick();
        tick();
        check("reset_outs", 32'({flags, fb_update, fb_changed, fb_count, bad_count,
                                  status_stale, wait_busy, wait_done, wait_ok}), 0);
        reset_n = 1'b1;
        model_reset();
    endtask

    // One byte transaction; wait_req/wait_cancel set by the caller apply to the acceptance cycle.
    task automatic send(input logic [7:0] b, input logic sm, input int hold);
        logic       fb;
        logic       take;
        logic       chg;
        logic       done;
        logic [3:0] fl;
        dataOut_bits  = b;
        dataOut_valid = 1'b1;
        script_mode   = sm;
        tick();
        fl   = b[5:2];
        take = !sm;
        fb   = take && (b[1:0] == 2'b01);
        chg  = fb && (fl != m_flags);
        done = m_armed && !wait_cancel && fb && (fl[m_sel] == m_lvl);
        if (fb) begin
            m_flags = fl;
            m_fbc   = m_fbc + 8'd1;
        end else if (take && m_bad != 8'hFF)
            m_bad = m_bad + 8'd1;
        if (done) begin
            m_armed = 1'b0;
            m_ok    = 1'b1;
        end else if (m_armed && wait_cancel)
            m_armed = 1'b0;
        else if (!m_armed && wait_req) begin
            m_armed = 1'b1;
            m_sel   = wait_sel;
            m_lvl   = wait_level;
            m_ok    = 1'b0;
        end
        wait_req    = 1'b0;
        wait_cancel = 1'b0;
        s_upd  = fb_update;
        s_chg  = fb_changed;
        s_done = wait_done;
        check("upd", 32'(fb_update), 32'(fb));
        check("chg", 32'(fb_changed), 32'(chg));
        check("flags", 32'(flags), 32'(m_flags));
        check("fb_count", 32'(fb_count), 32'(m_fbc));
        check("bad_count", 32'(bad_count), 32'(m_bad));
        check("done", 32'(wait_done), 32'(done));
        check("busy", 32'(wait_busy), 32'(m_armed));
        check("ok", 32'(wait_ok), 32'(m_ok));
        for (int i = 1; i < hold; i++) begin
            tick();
            check("hold_upd", 32'(fb_update), 0);
            check("hold_done", 32'(wait_done), 0);
        end
        dataOut_valid = 1'b0;
        script_mode   = 1'b0;
        tick();
    endtask

    task automatic arm(input logic [1:0] s, input logic l);
        wait_req   = 1'b1;
        wait_sel   = s;
        wait_level = l;
        tick();
        wait_req = 1'b0;
        m_armed  = 1'b1;
        m_sel    = s;
        m_lvl    = l;
        m_ok     = 1'b0;
        check("arm_busy", 32'(wait_busy), 1);
        check("arm_ok", 32'(wait_ok), 0);
    endtask

    task automatic cancel();
        wait_cancel = 1'b1;
        tick();
        wait_cancel = 1'b0;
        m_armed     = 1'b0;
        check("cancel_busy", 32'(wait_busy), 0);
        check("cancel_done", 32'(wait_done), 0);
    endtask

    initial begin
        int         cycles;
        logic [7:0] rb;
        model_reset();
        do_reset();

        send(8'h15, 1'b0, 1);
        check("t1_flags", 32'(flags), 'h5);
        check("t1_upd", 32'(s_upd), 1);
        check("t1_chg", 32'(s_chg), 1);
        check("t1_fbc", 32'(fb_count), 1);

        send(8'h15, 1'b0, 5);
        check("t2_upd", 32'(s_upd), 1);
        check("t2_chg", 32'(s_chg), 0);
        check("t2_fbc", 32'(fb_count), 2);

        send(8'h02, 1'b0, 1);
        send(8'hFF, 1'b0, 1);
        send(8'h15, 1'b1, 1);
        check("t3_bad", 32'(bad_count), 2);
        check("t3_fbc", 32'(fb_count), 2);
        check("t3_flags", 32'(flags), 'h5);

        send(8'h09, 1'b0, 1);
        arm(2'd1, 1'b1);
        send(8'h01, 1'b0, 1);
        check("t4_no_done", 32'(s_done), 0);
        send(8'h09, 1'b0, 2);
        check("t4_done", 32'(s_done), 1);
        check("t4_ok", 32'(wait_ok), 1);
        check("t4_busy", 32'(wait_busy), 0);

        arm(2'd0, 1'b1);
        dataOut_bits  = 8'h05;
        dataOut_valid = 1'b1;
        wait_cancel   = 1'b1;
        tick();
        check("t6_done", 32'(wait_done), 0);
        check("t6_busy", 32'(wait_busy), 0);
        check("t6_upd", 32'(fb_update), 1);
        wait_cancel   = 1'b0;
        dataOut_valid = 1'b0;
        wait_req      = 1'b1;
        wait_sel      = 2'd2;
        wait_level    = 1'b0;
        tick();
        wait_req = 1'b0;
        m_flags  = 4'h1;
        m_fbc    = m_fbc + 8'd1;
        m_armed  = 1'b1;
        m_sel    = 2'd2;
        m_lvl    = 1'b0;
        m_ok     = 1'b0;
        check("t6_rearm_busy", 32'(wait_busy), 1);
        check("t6_ok", 32'(wait_ok), 0);
        cancel();

        wait_req   = 1'b1;
        wait_sel   = 2'd0;
        wait_level = 1'b1;
        send(8'h05, 1'b0, 1);
        check("t7_no_done", 32'(s_done), 0);
        check("t7_busy", 32'(wait_busy), 1);
        send(8'h05, 1'b0, 1);
        check("t7_done", 32'(s_done), 1);

        arm(2'd3, 1'b1);
        do_reset();
`ifdef FEEDBACK_STALE_TIMER_EN
        arm(2'd0, 1'b1);
        cycles = 1;
        while (!status_stale && cycles < 100) begin
            tick();
            cycles++;
        end
        check("stale_cycles", 32'(cycles), 32);
        check("stale_busy", 32'(wait_busy), 1);
        tick();
        check("stale_done", 32'(wait_done), 1);
        check("stale_ok", 32'(wait_ok), 0);
        check("stale_busy_off", 32'(wait_busy), 0);
        m_armed = 1'b0;
        m_ok    = 1'b0;
        send(8'h05, 1'b0, 1);
        check("stale_clear", 32'(status_stale), 0);
`else
        arm(2'd0, 1'b1);
        for (int i = 0; i < 40; i++) tick();
        check("nostale_flag", 32'(status_stale), 0);
        check("nostale_busy", 32'(wait_busy), 1);
        cancel();
`endif

        reset_n       = 1'b0;
        dataOut_bits  = 8'h15;
        dataOut_valid = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        model_reset();
        tick();
        check("rel_upd", 32'(fb_update), 1);
        check("rel_fbc", 32'(fb_count), 1);
        m_flags       = 4'h5;
        m_fbc         = 8'd1;
        dataOut_valid = 1'b0;
        tick();

        for (int i = 0; i < 300; i++) begin
            rb = 8'($urandom);
            if ($urandom_range(0, 3) != 0) rb[1:0] = 2'b01;
            if (!m_armed && $urandom_range(0, 3) == 0)
                arm(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            wait_cancel = m_armed && ($urandom_range(0, 15) == 0);
            wait_req    = $urandom_range(0, 7) == 0;
            wait_sel    = 2'($urandom_range(0, 3));
            wait_level  = 1'($urandom_range(0, 1));
            send(rb, 1'($urandom_range(0, 7) == 0), int'($urandom_range(1, 3)));
        end
        if (m_armed) cancel();

        for (int i = 0; i < 256 && m_fbc != 8'd255; i++)
            send({2'($urandom), 4'($urandom), 2'b01}, 1'b0, 1);
        send(8'h01, 1'b0, 1);
        check("fbc_wrap", 32'(fb_count), 0);

        for (int i = 0; i < 260; i++)
            send({6'($urandom), 2'b10}, 1'b0, 1);
        check("bad_sat", 32'(bad_count), 255);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
